// File: rtl/truth_table_probe.sv
// truth_table_probe
//   Characterises one 3-input combinational gate. The block applies the eight
//   input rows 000..111 in order to in1/in2/in3 (in1 is the MSB of the row
//   index). Each row is held for SETTLE_CYCLES clocks, and then dut_out is
//   sampled into bit [row] of a shadow code. At the end of the sweep the
//   assembled 8-bit truth-table code is published and compared against the
//   expected code that was captured when start was accepted.
//
// Handshake: start is a level request. It is accepted only on a clock edge
//   where the block is IDLE; a request made while a sweep is in progress
//   (busy=1 or FINISH) is dropped, not queued. done pulses for one cycle
//   when tt_code/match/valid are updated.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset, wins over start
//   start     in   request a sweep
//   expected  in   [7:0] expected truth-table code, captured on acceptance
//   dut_out   in   output of the gate under test (sampled raw)
//   in1..in3  out  gate inputs, {in1,in2,in3} = current row index
//   busy      out  sweep in progress (SETTLE or FINISH)
//   done      out  one-cycle pulse when the result registers update
//   valid     out  tt_code holds a complete sweep result
//   tt_code   out  [7:0] bit r = dut_out sampled with row r applied
//   match     out  tt_code == captured expected (meaningful when valid)
//   state_dbg out  [1:0] current FSM state (0 IDLE, 1 SETTLE, 2 FINISH)

module truth_table_probe #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic [7:0] tt_code,
    output logic       match,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Counter value at which the current row is sampled.
    localparam logic [7:0] LAST_CNT = 8'(SETTLE_CYCLES - 1);

    state_t      state_q,   state_d;
    logic [2:0]  row_q,     row_d;
    logic [7:0]  cnt_q,     cnt_d;
    logic [7:0]  shadow_q,  shadow_d;
    logic [7:0]  exp_q,     exp_d;
    logic [7:0]  tt_code_q, tt_code_d;
    logic        match_q,   match_d;
    logic        valid_q,   valid_d;
    logic        done_q,    done_d;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        exp_d     = exp_q;
        tt_code_d = tt_code_q;
        match_d   = match_q;
        valid_d   = valid_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SETTLE;
                    row_d    = 3'd0;
                    cnt_d    = 8'd0;
                    shadow_d = 8'd0;
                    exp_d    = expected;
                end
            end
            SETTLE: begin
                if (cnt_q == LAST_CNT) begin
                    // Sample and advance on the same edge, so the next row is
                    // applied immediately after the sample.
                    cnt_d           = 8'd0;
                    shadow_d[row_q] = dut_out;
                    if (row_q == 3'd7) begin
                        state_d = FINISH;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FINISH: begin
                tt_code_d = shadow_q;
                match_d   = (shadow_q == exp_q);
                valid_d   = 1'b1;
                done_d    = 1'b1;
                row_d     = 3'd0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                row_d   = 3'd0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= 3'd0;
            cnt_q     <= 8'd0;
            shadow_q  <= 8'd0;
            exp_q     <= 8'd0;
            tt_code_q <= 8'd0;
            match_q   <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            exp_q     <= exp_d;
            tt_code_q <= tt_code_d;
            match_q   <= match_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    // row_q is 0 in IDLE and still 7 during FINISH, so the gate inputs
    // change only on clock edges and only once per row.
    assign in1       = row_q[2];
    assign in2       = row_q[1];
    assign in3       = row_q[0];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign valid     = valid_q;
    assign tt_code   = tt_code_q;
    assign match     = match_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_truth_table_probe.sv
// Bench for truth_table_probe. Three instances with SETTLE_CYCLES 4, 1 and 2
// share clock and reset; each drives a selectable gate model. Expected
// results are pushed to a queue when a sweep is issued and a monitor pops
// and compares on every done pulse.

module tb_truth_table_probe;

    localparam int SC [3] = '{4, 1, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start;
    logic [7:0] expected [3];
    logic [2:0] dut_out;
    logic [2:0] in1, in2, in3, busy, done, valid, match;
    logic [7:0] tt_code [3];
    logic [1:0] state_dbg [3];
    int         mode [3];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int n_pushed = 0;

    // {instance id[1:0], match, tt_code[7:0]}
    logic [10:0] exp_q [$];
    logic [10:0] mon_e;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        truth_table_probe #(.SETTLE_CYCLES(SC[g])) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start[g]),
            .expected  (expected[g]),
            .dut_out   (dut_out[g]),
            .in1       (in1[g]),
            .in2       (in2[g]),
            .in3       (in3[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .valid     (valid[g]),
            .tt_code   (tt_code[g]),
            .match     (match[g]),
            .state_dbg (state_dbg[g])
        );
    end

    // Gate models: 0 = XNOR(in1,in2) (code 0xC3), 1 = in3, 2 = in1,
    // 3 = constant 0, 4 = constant 1.
    always_comb begin
        dut_out = 3'b000;
        for (int g = 0; g < 3; g++) begin
            case (mode[g])
                0:       dut_out[g] = ~(in1[g] ^ in2[g]);
                1:       dut_out[g] = in3[g];
                2:       dut_out[g] = in1[g];
                3:       dut_out[g] = 1'b0;
                default: dut_out[g] = 1'b1;
            endcase
        end
    end

    function automatic int row_of(int g);
        return int'({in1[g], in2[g], in3[g]});
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (done[g] === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: instance %0d got done, required none", g);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_instance", g, {30'd0, mon_e[10:9]});
                    check("tt_code", {24'd0, tt_code[g]}, {24'd0, mon_e[7:0]});
                    check("match", {31'd0, match[g]}, {31'd0, mon_e[8]});
                    check("valid_at_done", {31'd0, valid[g]}, 1);
                    check("busy_at_done", {31'd0, busy[g]}, 0);
                end
            end
        end
    end

    task automatic push_exp(int g, logic [7:0] tt, logic m);
        exp_q.push_back({2'(g), m, tt});
        n_pushed++;
    endtask

    // One complete sweep on instance g; poke >= 1 re-pulses start during it.
    task automatic sweep(int g, int m, logic [7:0] exp_code, logic [7:0] req_tt,
                         logic req_match, int poke);
        int k, bcnt, prev, r, chg, bad;
        mode[g] = m;
        @(posedge clk);
        #1;
        start[g]    = 1'b1;
        expected[g] = exp_code;
        push_exp(g, req_tt, req_match);
        @(posedge clk);          // acceptance edge E0
        #1 start[g] = 1'b0;
        @(negedge clk);
        k    = 0;
        bcnt = busy[g] ? 1 : 0;
        prev = row_of(g);
        chg  = 0;
        bad  = 0;
        check("first_row", prev, 0);
        while (done[g] !== 1'b1 && k < 300) begin
            @(posedge clk);
            k++;
            #1 start[g] = (k == poke);
            @(negedge clk);
            if (busy[g]) bcnt++;
            r = row_of(g);
            if (busy[g] && r != prev) begin
                chg++;
                if (r != prev + 1) bad++;
                prev = r;
            end
        end
        start[g] = 1'b0;
        check("done_latency", k, 8 * SC[g] + 1);
        check("busy_cycles", bcnt, 8 * SC[g] + 1);
        check("row_changes", chg, 7);
        check("row_order_errors", bad, 0);
        check("rows_idle", row_of(g), 0);
    endtask

    initial begin
        int k, last_done, n_done, bad_int, idle_bad;
        rst   = 1'b1;
        start = 3'b000;
        for (int g = 0; g < 3; g++) begin
            expected[g] = 8'h00;
            mode[g]     = 3;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("rst_busy",  {31'd0, busy[g]},  0);
            check("rst_done",  {31'd0, done[g]},  0);
            check("rst_valid", {31'd0, valid[g]}, 0);
            check("rst_match", {31'd0, match[g]}, 0);
            check("rst_tt",    {24'd0, tt_code[g]}, 0);
            check("rst_rows",  row_of(g), 0);
            check("rst_state", {30'd0, state_dbg[g]}, 0);
        end
        rst = 1'b0;

        // Main function and row-to-bit mapping.
        sweep(0, 0, 8'hC3, 8'hC3, 1'b1, -1);
        sweep(0, 1, 8'hC3, 8'hAA, 1'b0, -1);
        sweep(0, 2, 8'hC3, 8'hF0, 1'b0, -1);

        // SETTLE_CYCLES = 1.
        sweep(1, 3, 8'h00, 8'h00, 1'b1, -1);
        sweep(1, 4, 8'h00, 8'hFF, 1'b0, -1);

        // start pulsed mid-sweep must be ignored.
        sweep(0, 0, 8'hC3, 8'hC3, 1'b1, 5);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("ignored_start_dones", done_cnt, n_pushed);
        check("ignored_start_idle", {31'd0, busy[0]}, 0);

        // Reset during row 4 after a 0xC3 result.
        mode[0] = 0;
        @(posedge clk);
        #1;
        start[0]    = 1'b1;
        expected[0] = 8'hC3;
        @(posedge clk);
        #1 start[0] = 1'b0;
        k = 0;
        @(negedge clk);
        while (row_of(0) != 4 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("reach_row4", row_of(0), 4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", {31'd0, valid[0]}, 0);
        check("midrst_tt",    {24'd0, tt_code[0]}, 0);
        check("midrst_match", {31'd0, match[0]}, 0);
        check("midrst_busy",  {31'd0, busy[0]}, 0);
        check("midrst_done",  {31'd0, done[0]}, 0);
        check("midrst_rows",  row_of(0), 0);
        check("midrst_state", {30'd0, state_dbg[0]}, 0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("midrst_no_done", done_cnt, n_pushed);
        sweep(0, 0, 8'hC3, 8'hC3, 1'b1, -1);

        // start held high for 100 edges, SETTLE_CYCLES = 2: accepted at
        // edges 1,19,37,55,73,91 -> done after edges 18,36,...,108.
        mode[2] = 0;
        @(posedge clk);
        #1;
        start[2]    = 1'b1;
        expected[2] = 8'hC3;
        for (int i = 0; i < 6; i++) push_exp(2, 8'hC3, 1'b1);
        last_done = 0;
        n_done    = 0;
        bad_int   = 0;
        idle_bad  = 0;
        for (k = 1; k <= 140; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 100) start[2] = 1'b0;
            if (done[2] === 1'b1) begin
                n_done++;
                if (n_done == 1) check("b2b_first_done", k, 18);
                else if (k - last_done != 18) bad_int++;
                last_done = k;
            end
            if (busy[2] !== 1'b1 && row_of(2) != 0) idle_bad++;
        end
        check("b2b_done_count", n_done, 6);
        check("b2b_interval_errors", bad_int, 0);
        check("b2b_idle_rows", idle_bad, 0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("total_dones", done_cnt, n_pushed);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/truth_table_probe.md
Name: truth_table_probe

Overview:
- Characterisation block for 3-input combinational gates: drives in1/in2/in3 into a gate under test, sweeps all 8 input rows, waits a settle time per row and samples the gate output.
- Assembles the 8-bit truth-table code that gates are named by (e.g. 0xC3).
- Compares the code against an expected value.
- Sits in the gate-library self-check harness, wrapped around any single 3-input gate.

Parameters:
- SETTLE_CYCLES, 4, cycles each input row is held before the gate output is sampled; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a sweep; honoured only in IDLE
- expected  input  8  expected truth-table code; captured when start is accepted
- dut_out  input  1  output of gate under test
- in1  output  1  gate input, MSB of row index
- in2  output  1  gate input, middle bit of row index
- in3  output  1  gate input, LSB of row index
- busy  output  1  high while a sweep is in progress
- done  output  1  one-cycle pulse when tt_code is updated
- valid  output  1  tt_code holds a complete sweep result
- tt_code  output  8  bit r = dut_out sampled with {in1,in2,in3}=r
- match  output  1  tt_code == captured expected; meaningful only when valid=1

Behaviour:
- Reset (rst high at a clk edge): state IDLE, in1..in3=0, busy=0, done=0, valid=0, tt_code=0x00, match=0, row index 0, settle counter 0.
- Reset mid-sweep: partial result discarded, all outputs return to reset values, no done pulse.
- rst has priority over start.
- States: IDLE, SETTLE, FINISH.
- IDLE:
  - start=1 at edge E0 -> SETTLE, row=0, {in1,in2,in3}=000, busy=1, counter=0, expected captured.
  - done is cleared at E0.
  - valid, tt_code and match hold their previous values until the new sweep completes.
- SETTLE:
  - Counter increments each edge.
  - At the edge where counter reaches SETTLE_CYCLES-1, dut_out is sampled into a shadow register bit [row] and the counter clears.
  - Row r is sampled at edge E0+(r+1)*SETTLE_CYCLES.
  - If row<7: row increments at the same edge, so the inputs change to the next row immediately after the sample.
  - If row=7 -> FINISH.
- FINISH (single cycle):
  - At the next edge, tt_code <= shadow, match <= (shadow==expected), valid=1, done=1, busy=0, inputs return to 000, state IDLE.
  - done is high for exactly one cycle, i.e. it is cleared at the following edge.
- Latency: done is visible in the cycle after edge E0+8*SETTLE_CYCLES+1. Total sweep is 8*SETTLE_CYCLES+1 cycles from acceptance to done.
- start while busy=1 or in FINISH: ignored; not queued.
- start held high continuously: a new sweep is accepted at the first edge in IDLE, giving back-to-back sweeps with one idle cycle.
- Inputs change only on clk edges, and exactly once per row, in Gray-free binary order 000..111.
- dut_out is sampled raw; the settle time covers gate propagation.
- SETTLE_CYCLES=1: a row is sampled at the edge after it is applied.
- Counter width: 8 bits.

Test Plan:
- Gate model out=1 for rows 000,001,110,111, SETTLE_CYCLES=4, start with expected=0xC3 -> done pulse 33 cycles after acceptance, tt_code=0xC3, valid=1, match=1, busy high for 33 cycles.
- dut_out=in3 with expected=0xC3 -> tt_code=0xAA, match=0. dut_out=in1 -> tt_code=0xF0. Confirms row-to-bit mapping and row order (in1 is MSB).
- SETTLE_CYCLES=1, dut_out tied 0, expected=0x00 -> done 9 cycles after start, tt_code=0x00, match=1. Then tie dut_out to 1 -> next sweep gives 0xFF, match=0.
- Pulse start again at cycle 5 of a sweep -> ignored: exactly one done pulse, and row sequence 000..111 is uninterrupted.
- Assert rst for one cycle during row 4 after a prior 0xC3 result -> all outputs at reset values next cycle (valid=0, tt_code=0x00), no done pulse. A subsequent start completes normally.
- Hold start high for 100 cycles with SETTLE_CYCLES=2 -> done pulses every 18 cycles (17-cycle sweep plus one IDLE cycle), with in1..in3=000 in each IDLE cycle.
